// File: rtl/omsp_spm_alloc_pkg.sv
// Shared defines for the secure protection-module allocator: FSM encoding,
// result codes and the reserved-ID constant.
package omsp_spm_alloc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_COMMIT = 3'd2,
        ST_UNPROT = 3'd3,
        ST_DONE   = 3'd4
    } spm_state_e;

    typedef enum logic [2:0] {
        SPM_OK      = 3'd0,
        SPM_BAD_CFG = 3'd1,
        SPM_OVERLAP = 3'd2,
        SPM_FULL    = 3'd3,
        SPM_ID_EXH  = 3'd4,
        SPM_ABORT   = 3'd5
    } spm_status_e;

    // IDs start at 1; the all-ones ID is reserved at any ID width.
    localparam int unsigned SPM_ID_FIRST         = 1;
    localparam logic        SPM_ID_RESERVED_FILL = 1'b1;

    function automatic logic spm_cfg_is_bad(input logic [15:0] pub_start,
                                            input logic [15:0] pub_end,
                                            input logic [15:0] sec_start,
                                            input logic [15:0] sec_end);
        return (pub_start >= pub_end) || (sec_start > sec_end);
    endfunction

endpackage

// File: rtl/omsp_spm_prio_enc.sv
// Lowest-index free slot selector: one-hot grant plus a valid flag when any
// slot is free.
module omsp_spm_prio_enc #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] free_i,
    output logic [N-1:0] onehot_o,
    output logic         valid_o
);

    always_comb begin
        logic found;
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        onehot_o = '0;
        found    = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (free_i[i] && !found) begin
                onehot_o[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign valid_o = |free_i;

endmodule

// File: rtl/omsp_spm_alloc.sv
// Protection-module slot allocator: validates a protect request, picks the
// lowest free slot and hands out a monotonically increasing module ID.
module omsp_spm_alloc
    import omsp_spm_alloc_pkg::*;
#(
    parameter int unsigned NUM_SPMS = 4,
    parameter int unsigned ID_W     = 16
) (
    input  logic                mclk,
    input  logic                puc_rst,
    input  logic                req_protect,
    input  logic                req_unprotect,
    input  logic                abort,
    input  logic [15:0]         r12,
    input  logic [15:0]         r13,
    input  logic [15:0]         r14,
    input  logic [15:0]         r15,
    input  logic [NUM_SPMS-1:0] slot_enabled,
    input  logic [NUM_SPMS-1:0] slot_create_viol,
    output logic [15:0]         cfg_pub_start,
    output logic [15:0]         cfg_pub_end,
    output logic [15:0]         cfg_sec_start,
    output logic [15:0]         cfg_sec_end,
    output logic                check_new_spm,
    output logic [NUM_SPMS-1:0] update_spm,
    output logic                enable_spm,
    output logic                disable_spm,
    output logic [ID_W-1:0]     next_id,
    output logic                busy,
    output logic                done,
    output logic [2:0]          status,
    output logic [ID_W-1:0]     new_id
);

    localparam logic [ID_W-1:0] ID_RESERVED = {ID_W{SPM_ID_RESERVED_FILL}};
    localparam logic [ID_W-1:0] ID_FIRST    = ID_W'(SPM_ID_FIRST);
    localparam logic [ID_W-1:0] ID_ONE      = ID_W'(1);

    spm_state_e            state_q, state_d;
    spm_status_e           status_q, status_d, check_result;
    logic [15:0]           pub_start_q, pub_start_d, pub_end_q, pub_end_d;
    logic [15:0]           sec_start_q, sec_start_d, sec_end_q, sec_end_d;
    logic                  check_q, check_d;
    logic [NUM_SPMS-1:0]   update_q, update_d;
    logic                  enable_q, enable_d;
    logic                  disable_q, disable_d;
    logic                  done_q, done_d;
    logic [ID_W-1:0]       next_id_q, next_id_d;
    logic [ID_W-1:0]       new_id_q, new_id_d;
    logic [NUM_SPMS-1:0]   free_onehot;
    logic                  free_valid;

    omsp_spm_prio_enc #(.N(NUM_SPMS)) u_prio_enc (
        .free_i   (~slot_enabled),
        .onehot_o (free_onehot),
        .valid_o  (free_valid)
    );

    // State register; every strobe is a flop so outputs never see inputs combinationally.
    always_ff @(posedge mclk) begin
        // NOTE: sequential state uses <= so all flops update together from pre-edge values.
        if (puc_rst) begin
            state_q     <= ST_IDLE;
            status_q    <= SPM_OK;
            pub_start_q <= '0;
            pub_end_q   <= '0;
            sec_start_q <= '0;
            sec_end_q   <= '0;
            check_q     <= 1'b0;
            update_q    <= '0;
            enable_q    <= 1'b0;
            disable_q   <= 1'b0;
            done_q      <= 1'b0;
            next_id_q   <= ID_FIRST;
            new_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            pub_start_q <= pub_start_d;
            pub_end_q   <= pub_end_d;
            sec_start_q <= sec_start_d;
            sec_end_q   <= sec_end_d;
            check_q     <= check_d;
            update_q    <= update_d;
            enable_q    <= enable_d;
            disable_q   <= disable_d;
            done_q      <= done_d;
            next_id_q   <= next_id_d;
            new_id_q    <= new_id_d;
        end
    end

    // Next-state logic; the CHECK verdict follows a fixed priority with abort first.
    always_comb begin
        check_result = SPM_OK;
        if (abort)
            check_result = SPM_ABORT;
        else if (spm_cfg_is_bad(pub_start_q, pub_end_q, sec_start_q, sec_end_q))
            check_result = SPM_BAD_CFG;
        else if (|(slot_create_viol & slot_enabled))
            check_result = SPM_OVERLAP;
        else if (!free_valid)
            check_result = SPM_FULL;
        else if (next_id_q == ID_RESERVED)
            check_result = SPM_ID_EXH;

        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_unprotect)
                    state_d = ST_UNPROT;
                else if (req_protect)
                    state_d = ST_CHECK;
            end
            ST_CHECK:  state_d = (check_result == SPM_OK) ? ST_COMMIT : ST_DONE;
            ST_COMMIT: state_d = ST_DONE;
            ST_UNPROT: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered strobes and data.
    always_comb begin
        pub_start_d = pub_start_q;
        pub_end_d   = pub_end_q;
        sec_start_d = sec_start_q;
        sec_end_d   = sec_end_q;
        status_d    = status_q;
        next_id_d   = next_id_q;
        new_id_d    = new_id_q;
        check_d     = 1'b0;
        update_d    = '0;
        enable_d    = 1'b0;
        disable_d   = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (state_d == ST_CHECK) begin
                    pub_start_d = r12;
                    pub_end_d   = r13;
                    sec_start_d = r14;
                    sec_end_d   = r15;
                    check_d     = 1'b1;
                end
                if (state_d == ST_UNPROT) begin
                    update_d  = '1;
                    disable_d = 1'b1;
                end
            end
            ST_CHECK: begin
                status_d = check_result;
                new_id_d = '0;
                if (state_d == ST_COMMIT) begin
                    update_d = free_onehot;
                    enable_d = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end
            ST_COMMIT: begin
                next_id_d = next_id_q + ID_ONE;
                new_id_d  = next_id_q;
                done_d    = 1'b1;
            end
            ST_UNPROT: begin
                status_d = SPM_OK;
                new_id_d = '0;
                done_d   = 1'b1;
            end
            ST_DONE:  new_id_d = '0;
            default: ;
        endcase
    end

    assign cfg_pub_start = pub_start_q;
    assign cfg_pub_end   = pub_end_q;
    assign cfg_sec_start = sec_start_q;
    assign cfg_sec_end   = sec_end_q;
    assign check_new_spm = check_q;
    assign update_spm    = update_q;
    assign enable_spm    = enable_q;
    assign disable_spm   = disable_q;
    assign next_id       = next_id_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign status        = status_q;
    assign new_id        = new_id_q;

endmodule

// File: doc/omsp_spm_alloc.md
OMSP_SPM_ALLOC -- requirements
Module: omsp_spm_alloc

Interface
REQ-001 Parameter NUM_SPMS, default 4, is the number of protection-module slots managed (1..16).
REQ-002 Parameter ID_W, default 16, is the width of the module ID.
REQ-003 mclk  input  1  single clock; all state updates on its rising edge.
REQ-004 puc_rst  input  1  reset; synchronous and active-high.
REQ-005 req_protect  input  1  pulse requesting creation of a new protected module.
REQ-006 req_unprotect  input  1  pulse requesting disable of the module owning the current pc.
REQ-007 abort  input  1  cancels a protect request still in CHECK.
REQ-008 r12, r13, r14, r15  input  16 each  public start/end and secret start/end of the request.
REQ-009 slot_enabled  input  NUM_SPMS  enabled flag per slot.
REQ-010 slot_create_viol  input  NUM_SPMS  per-slot overlap flag, valid while check_new_spm=1.
REQ-011 cfg_pub_start, cfg_pub_end, cfg_sec_start, cfg_sec_end  output  16 each  latched request config, driven to all slots.
REQ-012 check_new_spm  output  1  overlap check strobe to all slots.
REQ-013 update_spm  output  NUM_SPMS  one-hot (protect) or all-ones (unprotect) slot update strobe.
REQ-014 enable_spm, disable_spm  output  1 each  update qualifiers.
REQ-015 next_id  output  ID_W  ID given to the next committed module.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 status  output  3  result code, valid when done=1: OK=0, BAD_CFG=1, OVERLAP=2, FULL=3, ID_EXH=4, ABORT=5.
REQ-019 new_id  output  ID_W  ID assigned, valid with done and status=OK; otherwise 0.

Function
REQ-020 FSM states SHALL be IDLE, CHECK, COMMIT, UNPROT, DONE.
REQ-021 In IDLE, req_protect latches r12..r15 into cfg_* and moves to CHECK; requests outside IDLE are ignored (no queuing).
REQ-022 If req_protect and req_unprotect are both high in IDLE, unprotect wins and the protect request is dropped.
REQ-023 In CHECK, check_new_spm=1 for exactly one cycle; the next state is determined in the same cycle by priority: abort -> ABORT; cfg_pub_start>=cfg_pub_end or cfg_sec_start>cfg_sec_end -> BAD_CFG; any (slot_create_viol & slot_enabled) -> OVERLAP; all slots enabled -> FULL; next_id==all-ones -> ID_EXH; else COMMIT.
REQ-024 Any error in CHECK SHALL go to DONE with the matching status and no update_spm.
REQ-025 Slot selection: the lowest-index slot with slot_enabled=0; selection is registered on leaving CHECK.
REQ-026 In COMMIT, for one cycle: update_spm is one-hot on the selected slot, enable_spm=1; next_id increments by 1 on the same edge; new_id captures the pre-increment value.
REQ-027 abort is ignored in COMMIT; commit is atomic.
REQ-028 In UNPROT, for one cycle: update_spm is all-ones, disable_spm=1; then DONE with status OK and new_id=0.
REQ-029 DONE lasts one cycle with done=1, then returns to IDLE; latency req_protect->done is 3 cycles (OK) or 2 cycles (error); req_unprotect->done is 2 cycles.
REQ-030 next_id never wraps; all-ones is reserved and never assigned.
REQ-031 check_new_spm, update_spm, enable_spm, disable_spm and done SHALL be registered outputs, with no combinational path from inputs.

Reset
REQ-032 puc_rst SHALL force IDLE, next_id=1, cfg_*=0, status=0, new_id=0, and all strobes, busy and done to 0, including mid-operation; no update_spm is issued on or after the reset edge.

Structure
REQ-033 The status codes, FSM state encoding and reserved-ID constant SHALL live in the shared SPM defines package.
REQ-034 A single sub-module, omsp_spm_prio_enc (lowest-free-slot priority encoder with valid output), is natural.

Verification
REQ-035 Reset, then protect r12=0x8000, r13=0x8100, r14=0x0200, r15=0x0300 with no slots enabled -> update_spm=0001 at T+2, done at T+3 with status=0, new_id=1, next_id=2.
REQ-036 slot_enabled=0011 and slot_create_viol=0010 during CHECK -> done at T+2, status=2, no update_spm pulse, next_id unchanged.
REQ-037 r12=0x9000, r13=0x9000 -> status=1; slot_enabled=1111 with no overlap -> status=3.
REQ-038 req_protect and req_unprotect asserted together -> update_spm=1111 with disable_spm=1 at T+1, done at T+2, status=0, next_id unchanged.
REQ-039 abort asserted in CHECK -> status=5; puc_rst asserted in COMMIT -> no done pulse, next_id=1, busy=0 on the next cycle.
REQ-040 Preload next_id=0xFFFF, then protect -> status=4 and next_id remains 0xFFFF.
